// File: rtl/wb_csr_bridge_pkg.sv
// Shared bus definitions for the Wishbone-to-CSR bridge.
// Interconnect widths, CSR address default and FSM state encodings.
package wb_csr_bridge_pkg;

  localparam int WB_AW      = 32;
  localparam int WB_DW      = 32;
  localparam int CSR_AW_DEF = 14;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RWAIT = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/wb_csr_bridge.sv
// Wishbone slave to CSR bus bridge.
// Single-word accesses; reads wait RD_WAIT cycles for csr_di.
module wb_csr_bridge
  import wb_csr_bridge_pkg::*;
#(
  parameter int CSR_AW  = CSR_AW_DEF,
  parameter int RD_WAIT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [WB_AW-1:0]  wb_adr_i,
  input  logic [WB_DW-1:0]  wb_dat_i,
  output logic [WB_DW-1:0]  wb_dat_o,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  output logic              wb_ack_o,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [WB_DW-1:0]  csr_do,
  input  logic [WB_DW-1:0]  csr_di
);

  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_WAIT);

  state_e             r_state;
  state_e             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CSR_AW-1:0]  r_csr_a;
  logic [WB_DW-1:0]   r_csr_do;
  logic [WB_DW-1:0]   r_dat_o;
  logic               r_ack;
  logic               w_req;
  logic               w_csr_we;
  logic               w_unused;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_unused = ^{wb_adr_i[WB_AW-1:CSR_AW+2], wb_adr_i[1:0]};

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; dropping cyc aborts a transfer in flight
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req) w_next = wb_we_i ? ST_WRITE : ST_RWAIT;
      end
      ST_WRITE: begin
        w_next = wb_cyc_i ? ST_ACK : ST_IDLE;
      end
      ST_RWAIT: begin
        if (!wb_cyc_i)       w_next = ST_IDLE;
        else if (r_cnt == '0) w_next = ST_ACK;
      end
      ST_ACK: begin
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output decode: write strobe lasts exactly the WRITE cycle
  always_comb begin
    w_csr_we = 1'b0;
    if (r_state == ST_WRITE) w_csr_we = 1'b1;
  end

  // Datapath: latch request, count read wait, capture read data, ack
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt    <= '0;
      r_csr_a  <= '0;
      r_csr_do <= '0;
      r_dat_o  <= '0;
      r_ack    <= 1'b0;
    end else begin
      r_ack <= (w_next == ST_ACK);
      if (r_state == ST_IDLE && w_req) begin
        r_csr_a  <= wb_adr_i[CSR_AW+1:2];
        r_csr_do <= wb_dat_i;
        r_cnt    <= RD_INIT;
      end
      if (r_state == ST_RWAIT && wb_cyc_i) begin
        if (r_cnt == '0) r_dat_o <= csr_di;
        else             r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  assign wb_dat_o = r_dat_o;
  assign wb_ack_o = r_ack;
  assign csr_a    = r_csr_a;
  assign csr_we   = w_csr_we;
  assign csr_do   = r_csr_do;

endmodule

// File: tb/tb_wb_csr_bridge.sv
// Directed bench for wb_csr_bridge.
// Two instances: RD_WAIT=1 (dut1) and RD_WAIT=3 (dut3).
module tb_wb_csr_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        we  = 1'b0;
  logic [31:0] di  = '0;

  logic        cyc1 = 1'b0, stb1 = 1'b0;
  logic        cyc3 = 1'b0, stb3 = 1'b0;

  logic [31:0] dato1, do1, dato3, do3;
  logic [13:0] a1, a3;
  logic        ack1, we1, ack3, we3;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_csr_bridge #(.CSR_AW(14), .RD_WAIT(1)) u_dut1 (
    .sys_clk (clk),
    .sys_rst (rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat),
    .wb_dat_o(dato1),
    .wb_cyc_i(cyc1),
    .wb_stb_i(stb1),
    .wb_we_i (we),
    .wb_ack_o(ack1),
    .csr_a   (a1),
    .csr_we  (we1),
    .csr_do  (do1),
    .csr_di  (di)
  );

  wb_csr_bridge #(.CSR_AW(14), .RD_WAIT(3)) u_dut3 (
    .sys_clk (clk),
    .sys_rst (rst),
    .wb_adr_i(adr),
    .wb_dat_i(dat),
    .wb_dat_o(dato3),
    .wb_cyc_i(cyc3),
    .wb_stb_i(stb3),
    .wb_we_i (we),
    .wb_ack_o(ack3),
    .csr_a   (a3),
    .csr_we  (we3),
    .csr_do  (do3),
    .csr_di  (di)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    int nack;
    logic weh;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", 32'(ack1), 32'd0);
    check("rst_we", 32'(we1), 32'd0);
    check("rst_a", 32'(a1), 32'd0);
    check("rst_do", do1, 32'd0);
    check("rst_dato", dato1, 32'd0);
    rst = 1'b0;

    // single write
    adr = 32'h10; dat = 32'hDEAD_BEEF; we = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    @(negedge clk);
    check("wr_we_n1", 32'(we1), 32'd1);
    check("wr_a", 32'(a1), 32'd4);
    check("wr_do", do1, 32'hDEAD_BEEF);
    check("wr_ack_n1", 32'(ack1), 32'd0);
    @(negedge clk);
    check("wr_we_n2", 32'(we1), 32'd0);
    check("wr_ack_n2", 32'(ack1), 32'd1);
    cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk);
    check("wr_ack_n3", 32'(ack1), 32'd0);
    check("wr_dato", dato1, 32'd0);

    // single read, RD_WAIT=1
    adr = 32'h8; we = 1'b0; di = 32'h1234_5678;
    cyc1 = 1'b1; stb1 = 1'b1;
    weh = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      weh |= we1;
      if (i == 1) check("rd_a", 32'(a1), 32'd2);
      check($sformatf("rd_ack_n%0d", i), 32'(ack1),
            (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) begin
        check("rd_dato", dato1, 32'h1234_5678);
        cyc1 = 1'b0; stb1 = 1'b0;
      end
    end
    check("rd_we_never", 32'(weh), 32'd0);

    // back-to-back write then read, stb held
    adr = 32'h20; dat = 32'hA5A5_A5A5; we = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    nack = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (ack1) nack++;
      check($sformatf("b2b_ack_n%0d", i), 32'(ack1),
            (i == 2 || i == 6) ? 32'd1 : 32'd0);
      if (i == 2) begin
        we = 1'b0; adr = 32'h24; di = 32'hCAFE_F00D;
      end
      if (i == 3) check("b2b_hold_dato", dato1, 32'h1234_5678);
      if (i == 4) check("b2b_rd_a", 32'(a1), 32'd9);
      if (i == 6) begin
        check("b2b_dato", dato1, 32'hCAFE_F00D);
        cyc1 = 1'b0; stb1 = 1'b0;
      end
    end
    check("b2b_nack", 32'(nack), 32'd2);

    // read RD_WAIT=3, stb dropped with cyc held
    adr = 32'h30; we = 1'b0; di = 32'h1111_2222;
    cyc3 = 1'b1; stb3 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) stb3 = 1'b0;
      check($sformatf("rd3_ack_n%0d", i), 32'(ack3),
            (i == 5) ? 32'd1 : 32'd0);
      if (i == 5) begin
        check("rd3_dato", dato3, 32'h1111_2222);
        cyc3 = 1'b0;
      end
    end

    // abort in second RWAIT cycle
    adr = 32'h34; di = 32'h9999_9999;
    cyc3 = 1'b1; stb3 = 1'b1;
    weh = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cyc3 = 1'b0; stb3 = 1'b0;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      weh |= we3;
      if (ack3) nack++;
    end
    check("abort_nack", 32'(nack), 32'd0);
    check("abort_we", 32'(weh), 32'd0);
    check("abort_dato", dato3, 32'h1111_2222);

    // reset pulsed during RWAIT
    adr = 32'hC; we = 1'b0; di = 32'h0;
    cyc1 = 1'b1; stb1 = 1'b1;
    @(negedge clk);
    check("rr_a_pre", 32'(a1), 32'd3);
    rst = 1'b1;
    #1;
    check("rr_ack", 32'(ack1), 32'd0);
    check("rr_we", 32'(we1), 32'd0);
    check("rr_a", 32'(a1), 32'd0);
    check("rr_do", do1, 32'd0);
    check("rr_dato", dato1, 32'd0);
    check("rr_dato3", dato3, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    adr = 32'h4; dat = 32'h5; we = 1'b1;
    @(negedge clk);
    check("rr_wr_we", 32'(we1), 32'd1);
    check("rr_wr_a", 32'(a1), 32'd1);
    check("rr_wr_do", do1, 32'd5);
    check("rr_wr_ack_n1", 32'(ack1), 32'd0);
    @(negedge clk);
    check("rr_wr_ack_n2", 32'(ack1), 32'd1);
    cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk);
    check("rr_wr_ack_n3", 32'(ack1), 32'd0);

    // upper address bits ignored
    adr = 32'hFFFF_FFFC; dat = 32'h0; we = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    @(negedge clk);
    check("hi_a", 32'(a1), 32'h3FFF);
    @(negedge clk);
    check("hi_ack", 32'(ack1), 32'd1);
    cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_csr_bridge.md
WB_CSR_BRIDGE -- requirements
Module: wb_csr_bridge

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: sys_clk, sys_rst.
REQ-002 SHALL have parameter CSR_AW, default 14: CSR address width in words.
REQ-003 SHALL have parameter RD_WAIT, default 1: cycles between csr_a valid and csr_di sampling, legal range 1..7.
REQ-004 sys_clk  in  1  system clock; all state on rising edge.
REQ-005 sys_rst  in  1  asynchronous active-high reset.
REQ-006 wb_adr_i  in  32  Wishbone byte address from the interconnect slave port.
REQ-007 wb_dat_i  in  32  Wishbone write data.
REQ-008 wb_dat_o  out  32  Wishbone read data, registered.
REQ-009 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone cycle, strobe, write enable.
REQ-010 wb_ack_o  out  1  Wishbone acknowledge, registered single-cycle pulse.
REQ-011 csr_a  out  CSR_AW  CSR word address, equal to wb_adr_i[CSR_AW+1:2].
REQ-012 csr_we  out  1  CSR write strobe.
REQ-013 csr_do  out  32  CSR write data.
REQ-014 csr_di  in  32  CSR read data, valid RD_WAIT cycles after csr_a changes.

Function
REQ-015 FSM states SHALL be: IDLE, WRITE, RWAIT, ACK.
REQ-016 IDLE with cyc&stb at edge N: latch csr_a, csr_do <= wb_dat_i; go WRITE if we=1, else RWAIT with wait counter = RD_WAIT.
REQ-017 WRITE: csr_we SHALL be 1 for exactly this one cycle (N+1); go ACK.
REQ-018 RWAIT: counter decrements each cycle; on the cycle it reaches 0, wb_dat_o <= csr_di and go ACK.
REQ-019 ACK: wb_ack_o=1 for exactly one cycle; unconditional return to IDLE.
REQ-020 Write latency SHALL be: request at edge N, ack high in cycle N+2.
REQ-021 Read latency SHALL be: request at edge N, ack high in cycle N+RD_WAIT+2.
REQ-022 wb_sel_i is not present; every access SHALL be a full 32-bit word.
REQ-023 Upper address bits above CSR_AW+1 SHALL be ignored; decoding belongs to the interconnect.
REQ-024 A request in IDLE that coincides with the ACK-to-IDLE transition SHALL be accepted normally, giving back-to-back transfers with one IDLE cycle between acks.
REQ-025 cyc=0 in WRITE or RWAIT (abort) SHALL return to IDLE next edge, with no ack and no further csr_we.
REQ-026 Abort in WRITE SHALL NOT suppress the csr_we already asserted in that cycle.
REQ-027 stb=0 with cyc=1 SHALL NOT abort a transfer in progress.
REQ-028 wb_dat_o SHALL hold the last read value until the next read completes; writes SHALL NOT alter it.
REQ-029 csr_a and csr_do SHALL hold their values while IDLE.

Reset
REQ-030 sys_rst=1 SHALL immediately force state IDLE, wb_ack_o=0, csr_we=0, csr_a=0, csr_do=0, wb_dat_o=0, counter=0.
REQ-031 Reset asserted mid-transfer SHALL drop the transfer with no ack after release.
REQ-032 The first request SHALL be accepted on the first edge after reset deassertion.

Structure
REQ-033 State encodings and the CSR_AW default SHALL live in the shared bus definitions include, alongside the interconnect constants.
REQ-034 The block SHALL be a single module with no sub-module; the wait counter is inline, 3 bits wide.

Verification
REQ-035 Write adr=0x0000_0010, dat=0xDEAD_BEEF -> csr_a=4, csr_do=0xDEADBEEF, csr_we high in cycle N+1 only, ack in cycle N+2.
REQ-036 Read adr=0x0000_0008 with RD_WAIT=1 and csr_di=0x1234_5678 -> csr_a=2, ack in cycle N+3, wb_dat_o=0x12345678, csr_we never high.
REQ-037 Back-to-back write then read with stb held high -> exactly two single-cycle acks, one IDLE cycle between them, correct data.
REQ-038 Read with RD_WAIT=3 and cyc dropped in the second RWAIT cycle -> no ack, IDLE next cycle, wb_dat_o unchanged.
REQ-039 sys_rst pulsed during RWAIT -> all outputs 0 at once; after release, a write 0x5 to adr 0x4 completes in 2 cycles.
REQ-040 Address 0xFFFF_FFFC with CSR_AW=14 -> csr_a=0x3FFF (upper bits ignored).
